// File: rtl/packet_deframer_if.sv
// Bit-stream input and packet-stream output of the deframer, bundled as one link.
// master = bit source / packet consumer side, slave = the deframer itself.
interface packet_deframer_if #(
  parameter int PACKET_BYTES = 4
);
  logic                      bit_in;
  logic                      bit_valid;
  logic [PACKET_BYTES*8-1:0] pkt_data;
  logic                      pkt_valid;
  logic                      pkt_ready;

  modport master (
    output bit_in, bit_valid, pkt_ready,
    input  pkt_data, pkt_valid
  );

  modport slave (
    input  bit_in, bit_valid, pkt_ready,
    output pkt_data, pkt_valid
  );
endinterface

// File: rtl/packet_deframer.sv
// Sync-word hunter with Hamming tolerance and BPSK polarity resolution; frames fixed-size
// payloads into a small packet FIFO drained over valid/ready.
module packet_deframer #(
  parameter int                    SYNC_WIDTH      = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = 16'hD391,
  parameter int                    MAX_SYNC_ERRORS = 1,
  parameter int                    PACKET_BYTES    = 4,
  parameter int                    FIFO_DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  packet_deframer_if.slave        bus,
  output logic                    locked,
  output logic                    inverted,
  output logic                    overflow,
  output logic [7:0]              drop_count
);
  localparam int PW = PACKET_BYTES * 8;
  localparam int FW = $clog2(SYNC_WIDTH + 1);
  localparam int CW = $clog2(PW);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  state_t                state_q;
  logic [SYNC_WIDTH-1:0] sr_q, sr_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [CW-1:0]         bit_cnt_q;
  logic [PW-1:0]         pay_q, pay_d;
  logic                  inv_q;
  logic                  ovf_q;
  logic [7:0]            drop_q;
  logic [PW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         dist_norm, dist_inv;
  logic                  sync_full, hit_norm, hit_inv;
  logic                  last_bit, push_req, push_ok, pop;

  function automatic logic [FW-1:0] popcount(input logic [SYNC_WIDTH-1:0] v);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < SYNC_WIDTH; i++) n = n + FW'(v[i]);
    return n;
  endfunction

  always_comb begin
    sr_d      = {sr_q[SYNC_WIDTH-2:0], bus.bit_in};
    fill_d    = (fill_q == FW'(SYNC_WIDTH)) ? fill_q : fill_q + FW'(1);
    dist_norm = popcount(sr_d ^ SYNC_WORD);
    dist_inv  = popcount(sr_d ^ ~SYNC_WORD);
    sync_full = (fill_d == FW'(SYNC_WIDTH));
    hit_norm  = sync_full && (dist_norm <= FW'(MAX_SYNC_ERRORS));
    hit_inv   = sync_full && (dist_inv <= FW'(MAX_SYNC_ERRORS));
    pay_d     = {pay_q[PW-2:0], bus.bit_in ^ inv_q};
    last_bit  = (bit_cnt_q == CW'(PW - 1));
    pop       = (cnt_q != '0) && bus.pkt_ready;
    push_req  = bus.bit_valid && (state_q == COLLECT) && last_bit;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push_ok   = push_req && ((cnt_q < NW'(FIFO_DEPTH)) || pop);
    cnt_d     = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + NW'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - NW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      pay_q     <= '0;
      inv_q     <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ovf_q <= 1'b0;
      if (bus.bit_valid) begin
        case (state_q)
          HUNT: begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
            if (hit_norm) begin
              state_q <= COLLECT;
              inv_q   <= 1'b0;
            end else if (hit_inv) begin
              state_q <= COLLECT;
              inv_q   <= 1'b1;
            end
          end
          COLLECT: begin
            pay_q <= pay_d;
            if (last_bit) begin
              // Payload bits must never seed the next sync search.
              bit_cnt_q <= '0;
              state_q   <= HUNT;
              sr_q      <= '0;
              fill_q    <= '0;
              if (!push_ok) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= pay_d;
  end

  assign bus.pkt_valid = (cnt_q != '0);
  assign bus.pkt_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign locked        = (state_q == COLLECT);
  assign inverted      = inv_q;
  assign overflow      = ovf_q;
  assign drop_count    = drop_q;
endmodule
